// File: rtl/serial_add_sub_pkg.sv
// Shared constants for the bit-serial adder/subtractor: FSM state encoding and op select.
package serial_add_sub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the serial bit slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one result bit per clock, LSB first,
// result/cout/overflow presented with a one-cycle done pulse.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_nxt;
  logic [CW-1:0]    count;
  logic             carry;
  logic             s_bit;
  logic             c_bit;
  logic             accept;
  logic             last;
  logic             busy_nxt;
  logic             done_nxt;

  full_adder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .sum (s_bit),
    .cout(c_bit)
  );

  // A new request is taken whenever no operation is in flight.
  assign accept = start && (state != ST_SHIFT);
  assign last   = (state == ST_SHIFT) && (count == CW'(WIDTH - 1));
  assign r_nxt  = (r_sh >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last)  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; flags trail the state register by one cycle.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state)
      ST_SHIFT: busy_nxt = 1'b1;
      ST_DONE:  done_nxt = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Serial datapath; subtraction is a + ~b + 1 via the preset carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      count    <= '0;
      carry    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh  <= op_a;
      b_sh  <= op_b ^ {WIDTH{sub == OP_SUB}};
      carry <= (sub == OP_SUB);
      count <= '0;
    end else if (state == ST_SHIFT) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      r_sh  <= r_nxt;
      carry <= c_bit;
      count <= count + CW'(1);
      if (last) begin
        result   <= r_nxt;
        cout     <= c_bit;
        overflow <= c_bit ^ carry;
      end
    end
  end

endmodule
